// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle RV32I core
// Moore strobes decoded from the state register; retired-instruction counter on completion.
module multicycle_control #(
    parameter int COUNT_W         = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic               clockCPU,
    input  logic               reset,
    input  logic [31:0]        iInst,
    output logic               oRegWrite,
    output logic [1:0]         oALUSrcA,
    output logic [1:0]         oALUSrcB,
    output logic [1:0]         oALUOp,
    output logic               oMemRead,
    output logic               oMemWrite,
    output logic               oMemtoReg,
    output logic               oIoD,
    output logic               oIRWrite,
    output logic               oPCWrite,
    output logic               oPCWriteCond,
    output logic               oPCSource,
    output logic               oIllegal,
    output logic [3:0]         oState,
    output logic [COUNT_W-1:0] oRetired
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 retire;
    logic                 unused_inst;

    assign opcode      = iInst[6:0];
    assign funct3      = iInst[14:12];
    assign unused_inst = &{1'b0, iInst[31:15], iInst[11:7]};

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Every completing state returns to FETCH, so retirement is simply "in a completing state".
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BRANCH);

    always_comb begin
        retired_d = retire ? retired_q + COUNT_W'(1) : retired_q;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE)
                    state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)
                    state_d = S_EXEC_R;
                else if (opcode == OP_ITYPE)
                    state_d = S_EXEC_I;
                else if (opcode == OP_BRANCH && funct3 == 3'b000)
                    state_d = S_BRANCH;
                else
                    state_d = S_ILLEGAL;
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        oRegWrite    = 1'b0;
        oALUSrcA     = 2'b00;
        oALUSrcB     = 2'b00;
        oALUOp       = 2'b00;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oMemtoReg    = 1'b0;
        oIoD         = 1'b0;
        oIRWrite     = 1'b0;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oPCSource    = 1'b0;
        oIllegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                oMemRead = 1'b1;
                oIRWrite = 1'b1;
                oALUSrcB = 2'b01;
                oPCWrite = 1'b1;
            end
            S_DECODE: begin
                oALUSrcA = 2'b10;
                oALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                oMemRead = 1'b1;
                oIoD     = 1'b1;
            end
            S_MEMWB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                oMemWrite = 1'b1;
                oIoD      = 1'b1;
            end
            S_EXEC_R: begin
                oALUSrcA = 2'b01;
                oALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b10;
                oALUOp   = 2'b11;
            end
            S_ALUWB: oRegWrite = 1'b1;
            S_BRANCH: begin
                oALUSrcA     = 2'b01;
                oALUOp       = 2'b01;
                oPCWriteCond = 1'b1;
                oPCSource    = 1'b1;
            end
            S_ILLEGAL: oIllegal = 1'b1;
            default: ;
        endcase
    end

    assign oState   = state_q;
    assign oRetired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
// dut0: default parameters, random instruction stream; dut1: COUNT_W=4, HALT_ON_ILLEGAL=1.
module tb_multicycle_control;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMREAD = 4,
                   ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXEC_R = 7, ST_EXEC_I = 8, ST_ALUWB = 9,
                   ST_BRANCH = 10, ST_ILLEGAL = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [31:0] inst0, inst1;

    logic        rw0, mr0, mw0, m2r0, iod0, irw0, pcw0, pcwc0, pcs0, ill0;
    logic [1:0]  sa0, sb0, op0;
    logic [3:0]  st0;
    logic [31:0] ret0;

    logic        rw1, mr1, mw1, m2r1, iod1, irw1, pcw1, pcwc1, pcs1, ill1;
    logic [1:0]  sa1, sb1, op1;
    logic [3:0]  st1;
    logic [3:0]  ret1;

    multicycle_control dut0 (
        .clockCPU(clk), .reset(rst0), .iInst(inst0),
        .oRegWrite(rw0), .oALUSrcA(sa0), .oALUSrcB(sb0), .oALUOp(op0),
        .oMemRead(mr0), .oMemWrite(mw0), .oMemtoReg(m2r0), .oIoD(iod0),
        .oIRWrite(irw0), .oPCWrite(pcw0), .oPCWriteCond(pcwc0), .oPCSource(pcs0),
        .oIllegal(ill0), .oState(st0), .oRetired(ret0)
    );

    multicycle_control #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clockCPU(clk), .reset(rst1), .iInst(inst1),
        .oRegWrite(rw1), .oALUSrcA(sa1), .oALUSrcB(sb1), .oALUOp(op1),
        .oMemRead(mr1), .oMemWrite(mw1), .oMemtoReg(m2r1), .oIoD(iod1),
        .oIRWrite(irw1), .oPCWrite(pcw1), .oPCWriteCond(pcwc1), .oPCSource(pcs1),
        .oIllegal(ill1), .oState(st1), .oRetired(ret1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe word: {RegWrite, SrcA, SrcB, ALUOp, MemRead, MemWrite, MemtoReg, IoD, IRWrite,
    //               PCWrite, PCWriteCond, PCSource, Illegal}
    function automatic logic [15:0] strobes_for(input int st);
        logic       rw, mr, mw, m2r, iod, irw, pcw, pcwc, pcs, ill;
        logic [1:0] sa, sb, op;
        {rw, mr, mw, m2r, iod, irw, pcw, pcwc, pcs, ill} = '0;
        {sa, sb, op} = '0;
        case (st)
            ST_FETCH:    begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
            ST_DECODE:   begin sa = 2'b10; sb = 2'b10; end
            ST_MEMADR:   begin sa = 2'b01; sb = 2'b10; end
            ST_MEMREAD:  begin mr = 1; iod = 1; end
            ST_MEMWB:    begin rw = 1; m2r = 1; end
            ST_MEMWRITE: begin mw = 1; iod = 1; end
            ST_EXEC_R:   begin sa = 2'b01; op = 2'b10; end
            ST_EXEC_I:   begin sa = 2'b01; sb = 2'b10; op = 2'b11; end
            ST_ALUWB:    rw = 1;
            ST_BRANCH:   begin sa = 2'b01; op = 2'b01; pcwc = 1; pcs = 1; end
            ST_ILLEGAL:  ill = 1;
            default: ;
        endcase
        return {rw, sa, sb, op, mr, mw, m2r, iod, irw, pcw, pcwc, pcs, ill};
    endfunction

    typedef struct {
        int          st;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_ret;

    task automatic push(input int s);
        exp_t e;
        e.st  = s;
        e.ret = model_ret;
        sb_q.push_back(e);
    endtask

    // Reference: the instruction's visible state walk and whether it retires.
    task automatic push_instr(input logic [31:0] ins, output int n);
        logic [6:0] opc;
        int         walk[$];
        bit         retires;
        opc     = ins[6:0];
        retires = 1'b1;
        if (opc == 7'b0000011)                          walk = '{1, 2, 3, 4, 5};
        else if (opc == 7'b0100011)                     walk = '{1, 2, 3, 6};
        else if (opc == 7'b0110011)                     walk = '{1, 2, 7, 9};
        else if (opc == 7'b0010011)                     walk = '{1, 2, 8, 9};
        else if (opc == 7'b1100011 && ins[14:12] == 0)  walk = '{1, 2, 10};
        else begin
            walk    = '{1, 2, 11};
            retires = 1'b0;
        end
        foreach (walk[i]) push(walk[i]);
        n = walk.size();
        if (retires) model_ret = model_ret + 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run0(input logic [31:0] ins);
        int n;
        inst0 = ins;
        push_instr(ins, n);
        step(n);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2: r[6:0] = 7'b0110011;
            3: r[6:0] = 7'b0010011;
            4: begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
            5: begin r[6:0] = 7'b1100011; r[14:12] = 3'($urandom_range(1, 7)); end
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("state", 64'(st0), 64'(e.st));
            chk("strobes", 64'({rw0, sa0, sb0, op0, mr0, mw0, m2r0, iod0, irw0, pcw0, pcwc0, pcs0, ill0}),
                64'(strobes_for(e.st)));
            chk("retired", 64'(ret0), 64'(e.ret));
            chk("mem_excl", 64'(mr0 & mw0), 64'd0);
            chk("rw_pcw_excl", 64'(rw0 & pcw0), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; inst0 = '0; inst1 = '0;
        model_ret = '0;
        step(2);
        push(ST_IDLE);
        step(1);
        rst0 = 1'b0;
        push(ST_IDLE);
        step(1);

        run0(32'h0080A283);   // lw  x5,8(x1)
        run0(32'h0020A223);   // sw  x2,4(x1)
        run0(32'h002081B3);   // add x3,x1,x2
        run0(32'h00208863);   // beq x1,x2,+16
        run0(32'h0000007F);   // illegal opcode
        run0(32'h00209863);   // bne: illegal here
        for (int i = 0; i < 150; i++) run0(rand_instr());

        // Abort a store in MEMWRITE with an asynchronous reset.
        inst0 = 32'h0020A223;
        push(ST_FETCH); push(ST_DECODE); push(ST_MEMADR);
        step(3);
        #1;
        chk("pre_rst_memwrite", 64'(mw0), 64'd1);
        rst0 = 1'b1;
        #1;
        chk("rst_memwrite", 64'(mw0), 64'd0);
        chk("rst_iod", 64'(iod0), 64'd0);
        chk("rst_state", 64'(st0), 64'd0);
        chk("rst_retired", 64'(ret0), 64'd0);
        model_ret = '0;
        step(1);
        push(ST_IDLE);
        step(1);
        rst0 = 1'b0;
        push(ST_IDLE);
        step(1);
        run0(32'h0080A283);
        run0(32'h002081B3);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        // Narrow counter wrap, then terminal illegal.
        rst1 = 1'b0;
        step(1);
        inst1 = 32'h00108093;   // addi x1,x1,1
        for (int i = 1; i <= 17; i++) begin
            step(4);
            if (i >= 15) begin
                chk("wrap_state", 64'(st1), 64'(ST_FETCH));
                chk("wrap_retired", 64'(ret1), 64'(i % 16));
            end
        end
        inst1 = 32'h0000007F;
        step(2);
        for (int i = 0; i < 5; i++) begin
            chk("halt_state", 64'(st1), 64'(ST_ILLEGAL));
            chk("halt_illegal", 64'(ill1), 64'd1);
            chk("halt_retired", 64'(ret1), 64'd1);
            step(1);
        end
        rst1 = 1'b1;
        #1;
        chk("halt_rst_state", 64'(st1), 64'd0);
        chk("halt_rst_illegal", 64'(ill1), 64'd0);
        chk("halt_rst_retired", 64'(ret1), 64'd0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
